// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump UART path.
package reg_dump_pkg;

    // Top-level sequencing: wait for start, latch a word, stream its bytes.
    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_LOAD,
        TOP_SEND
    } top_state_t;

    // Byte transmitter frame states.
    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START_BIT,
        UART_DATA,
        UART_STOP_BIT
    } uart_state_t;

    // UART 8N1 frame constants.
    localparam logic        START_LEVEL    = 1'b0;
    localparam logic        STOP_LEVEL     = 1'b1;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte idx of a word, most-significant byte first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter with valid/ready handshake.
// Ready is raised in IDLE and in the last cycle of the stop bit, so a byte
// offered then starts its start bit with no idle gap.
module uart_tx_byte
    import reg_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t       state, state_next;
    logic [BAUD_W-1:0] baud, baud_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shreg, shreg_next;
    logic              tx_next;
    logic              bit_end;

    assign bit_end    = (baud == BAUD_LAST);
    assign byte_ready = (state == UART_IDLE) || ((state == UART_STOP_BIT) && bit_end);

    // Frame sequencing: next state, baud count, shift register and line level.
    always_comb begin
        state_next   = state;
        baud_next    = baud + 1'b1;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        tx_next      = tx;
        case (state)
            UART_IDLE: begin
                baud_next = '0;
                tx_next   = STOP_LEVEL;
                if (byte_valid) begin
                    state_next   = UART_START_BIT;
                    shreg_next   = byte_data;
                    bit_idx_next = '0;
                    tx_next      = START_LEVEL;
                end
            end
            UART_START_BIT: begin
                if (bit_end) begin
                    state_next   = UART_DATA;
                    baud_next    = '0;
                    bit_idx_next = '0;
                    tx_next      = shreg[0];
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_next = UART_STOP_BIT;
                        tx_next    = STOP_LEVEL;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shreg_next   = {1'b0, shreg[7:1]};
                        tx_next      = shreg[1];
                    end
                end
            end
            UART_STOP_BIT: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (byte_valid) begin
                        state_next   = UART_START_BIT;
                        shreg_next   = byte_data;
                        bit_idx_next = '0;
                        tx_next      = START_LEVEL;
                    end else begin
                        state_next = UART_IDLE;
                        tx_next    = STOP_LEVEL;
                    end
                end
            end
            default: begin
                state_next = UART_IDLE;
                baud_next  = '0;
                tx_next    = STOP_LEVEL;
            end
        endcase
    end

    // State register; reset aborts any frame and returns the line high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= UART_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= STOP_LEVEL;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            tx      <= tx_next;
        end
    end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Register-file dump engine: walks addresses 0..NUM_REGS-1 through a
// combinational read port and sends each word MSB byte first over UART 8N1.
module reg_dump_uart_tx
    import reg_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned NUM_REGS     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] ADDR_LAST = 5'(NUM_REGS - 1);
    localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_WORD - 1);

    top_state_t  state, state_next;
    logic [31:0] word, word_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [4:0]  reg_addr_next;
    logic        busy_next;
    logic        done_next;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;

    // Word/byte/address sequencing around the byte transmitter.
    always_comb begin
        state_next    = state;
        word_next     = word;
        byte_idx_next = byte_idx;
        reg_addr_next = reg_addr;
        busy_next     = busy;
        done_next     = 1'b0;
        byte_valid    = 1'b0;
        byte_data     = word_byte(word, byte_idx + 2'd1);
        case (state)
            TOP_IDLE: begin
                if (start) begin
                    state_next    = TOP_LOAD;
                    busy_next     = 1'b1;
                    reg_addr_next = '0;
                end
            end
            TOP_LOAD: begin
                // Byte 0 is handed over straight from reg_data in the same
                // cycle it is latched, so the start bit follows LOAD directly.
                word_next     = reg_data;
                byte_idx_next = '0;
                byte_data     = word_byte(reg_data, 2'd0);
                byte_valid    = 1'b1;
                state_next    = TOP_SEND;
            end
            TOP_SEND: begin
                if (byte_ready) begin
                    if (byte_idx != BYTE_LAST) begin
                        byte_valid    = 1'b1;
                        byte_idx_next = byte_idx + 2'd1;
                    end else if (reg_addr != ADDR_LAST) begin
                        reg_addr_next = reg_addr + 5'd1;
                        state_next    = TOP_LOAD;
                    end else begin
                        done_next     = 1'b1;
                        busy_next     = 1'b0;
                        reg_addr_next = '0;
                        state_next    = TOP_IDLE;
                    end
                end
            end
            default: begin
                state_next = TOP_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Registered state and outputs; reset aborts without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= TOP_IDLE;
            word     <= '0;
            byte_idx <= '0;
            reg_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            word     <= word_next;
            byte_idx <= byte_idx_next;
            reg_addr <= reg_addr_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clock     (clock),
        .reset     (reset),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx        (tx)
    );

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Scoreboard bench for reg_dump_uart_tx: expected bytes are queued from a
// register-file model at start; a line decoder pops and compares each frame.
module tb_reg_dump_uart_tx;

    localparam int unsigned C        = 4;
    localparam int unsigned N        = 32;
    localparam int unsigned C2       = 2;
    localparam int unsigned WORD_CYC = 1 + 40 * C;
    localparam int unsigned DONE_CYC = N * WORD_CYC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        tx, busy, done;

    logic        start2 = 1'b0;
    logic [4:0]  reg_addr2;
    logic [31:0] reg_data2;
    logic        tx2, busy2, done2;

    logic [31:0] rf [N];
    logic [31:0] rf2;

    assign reg_data  = rf[reg_addr];
    assign reg_data2 = rf2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int e0       = 0;
    int done_due = -1;
    int done_cnt = 0;

    logic [7:0] exp_q[$];

    reg_dump_uart_tx #(.CLKS_PER_BIT(C), .NUM_REGS(N)) dut (
        .clock(clock), .reset(reset), .start(start), .reg_addr(reg_addr),
        .reg_data(reg_data), .tx(tx), .busy(busy), .done(done)
    );

    reg_dump_uart_tx #(.CLKS_PER_BIT(C2), .NUM_REGS(1)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .reg_addr(reg_addr2),
        .reg_data(reg_data2), .tx(tx2), .busy(busy2), .done(done2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line decoder: aligns on a falling edge, requires every cycle of a bit to hold its level.
    logic       prev_tx    = 1'b1;
    bit         dec_active = 1'b0;
    bit         dec_glitch;
    int         dec_cyc;
    int         dec_bit;
    logic       lvl [10];
    logic [7:0] dec_byte;
    logic [7:0] dec_exp;

    always @(negedge clock) begin
        if (reset) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                dec_active = 1'b1;
                dec_glitch = 1'b0;
                dec_cyc    = 1;
                lvl[0]     = tx;
            end
        end else begin
            dec_bit = dec_cyc / C;
            if (dec_cyc % C == 0) lvl[dec_bit] = tx;
            else if (tx !== lvl[dec_bit]) dec_glitch = 1'b1;
            if (dec_cyc == 10 * C - 1) begin
                dec_active = 1'b0;
                for (int i = 0; i < 8; i++) dec_byte[i] = lvl[i + 1];
                if (exp_q.size() == 0) begin
                    check("uart_byte_unexpected", {55'd0, 1'b1, dec_byte}, 64'd0);
                end else begin
                    dec_exp = exp_q.pop_front();
                    check("uart_frame{glitch,stop,start,data}",
                          {53'd0, dec_glitch, lvl[9], lvl[0], dec_byte},
                          {53'd0, 1'b0, 1'b1, 1'b0, dec_exp});
                end
            end else begin
                dec_cyc++;
            end
        end
        prev_tx = reset ? 1'b1 : tx;
    end

    // Done monitor: latency from E0 and busy low in the done cycle.
    always @(negedge clock) begin
        if (!reset && done) begin
            done_cnt++;
            if (done_due < 0) begin
                check("done_unexpected", {63'd0, done}, 64'd0);
            end else begin
                check("done_latency", 64'(cyc - e0), 64'(done_due));
                check("busy_at_done", {63'd0, busy}, 64'd0);
                done_due = -1;
            end
        end
    end

    task automatic run_dump(input bit mutate, input bit extra_starts, input int abort_at);
        int dc0;
        int k;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(rf[a] >> (24 - 8 * b)));
        dc0 = done_cnt;
        @(negedge clock);
        #1 start = 1'b1;
        @(negedge clock);
        e0 = cyc;
        done_due = (abort_at > 0) ? -1 : int'(DONE_CYC);
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("addr_after_start", {59'd0, reg_addr}, 64'd0);
        #1 start = 1'b0;
        for (int t = 1; t <= int'(DONE_CYC) + 20; t++) begin
            @(negedge clock);
            if (abort_at > 0 && t == abort_at + 1) begin
                check("abort_tx", {63'd0, tx}, 64'd1);
                check("abort_busy", {63'd0, busy}, 64'd0);
                check("abort_done", {63'd0, done}, 64'd0);
                check("abort_addr", {59'd0, reg_addr}, 64'd0);
                exp_q.delete();
                #1 reset = 1'b0;
            end else if (abort_at > 0 && t >= abort_at + 200) begin
                break;
            end
            if (done_cnt != dc0) break;
            if (t % WORD_CYC == 20 && (abort_at == 0 || t < abort_at)) begin
                k = t / WORD_CYC;
                check("addr_stable_in_word", {59'd0, reg_addr}, 64'(k));
                if (mutate) rf[k] = $urandom;
            end
            if (t == 2000 && abort_at == 0) check("busy_mid_dump", {63'd0, busy}, 64'd1);
            if (extra_starts && (t == 10 || t == 300)) #1 start = 1'b1;
            if (extra_starts && (t == 11 || t == 301)) #1 start = 1'b0;
            if (t == abort_at) #1 reset = 1'b1;
        end
        if (abort_at > 0) begin
            check("no_done_after_abort", 64'(done_cnt - dc0), 64'd0);
        end else begin
            repeat (30) @(negedge clock);
            check("done_count", 64'(done_cnt - dc0), 64'd1);
            check("bytes_left", 64'(exp_q.size()), 64'd0);
            check("idle_tx", {63'd0, tx}, 64'd1);
            check("idle_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic run_short();
        int         bad;
        int         bi;
        int         pos;
        logic [7:0] by;
        logic       lv;
        rf2 = $urandom;
        @(negedge clock);
        #1 start2 = 1'b1;
        @(negedge clock);
        e0 = cyc;
        check("short_busy", {63'd0, busy2}, 64'd1);
        #1 start2 = 1'b0;
        bad = 0;
        for (int t = 1; t <= 84; t++) begin
            @(negedge clock);
            if (t <= 80) begin
                bi  = (t - 1) / C2;
                pos = bi % 10;
                by  = 8'(rf2 >> (24 - 8 * (bi / 10)));
                lv  = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : by[pos - 1];
                if (tx2 !== lv) bad++;
            end
            if (t == 80) check("short_done_early", {63'd0, done2}, 64'd0);
            if (t == 81) begin
                check("short_done", {63'd0, done2}, 64'd1);
                check("short_busy_at_done", {63'd0, busy2}, 64'd0);
                check("short_tx_bit_errors", 64'(bad), 64'd0);
                check("short_addr", {59'd0, reg_addr2}, 64'd0);
            end
            if (t == 82) check("short_done_pulse", {63'd0, done2}, 64'd0);
        end
    endtask

    initial begin
        for (int a = 0; a < N; a++) rf[a] = 32'(a) * 32'h01010101;
        rf2 = '0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("reset_tx", {63'd0, tx}, 64'd1);
            check("reset_busy", {63'd0, busy}, 64'd0);
            check("reset_done", {63'd0, done}, 64'd0);
            check("reset_addr", {59'd0, reg_addr}, 64'd0);
            check("reset_tx2", {63'd0, tx2}, 64'd1);
        end
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("idle_tx_after_reset", {63'd0, tx}, 64'd1);
            check("idle_busy_after_reset", {63'd0, busy}, 64'd0);
        end

        run_dump(1'b0, 1'b1, 0);

        for (int a = 0; a < N; a++) rf[a] = $urandom;
        rf[1] = 32'h11223344;
        run_dump(1'b1, 1'b0, 0);

        run_dump(1'b0, 1'b0, int'(5 * WORD_CYC) + 15);

        for (int a = 0; a < N; a++) rf[a] = $urandom;
        run_dump(1'b0, 1'b0, 0);

        run_short();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
